// File: rtl/output_mode_pkg.sv
// Shared output-mode definitions for the sequencer and output_mode_fsm.
package output_mode_pkg;

   typedef enum logic [2:0] {
      OFF_MODE   = 3'b000,
      PWM_MODE   = 3'b001,
      R2R_MODE   = 3'b010,
      SAW_MODE   = 3'b011,
      BUZ_MODE   = 3'b100,
      CHRIP_MODE = 3'b101
   } mode_t;

   // Codes 110 and 111 have no output mode behind them.
   function automatic logic is_valid_mode(input logic [2:0] code);
      return (code <= 3'b101);
   endfunction

   // Auto-scan order: OFF only ever starts the sequence, CHIRP wraps to PWM.
   function automatic mode_t next_scan_mode(input mode_t cur);
      mode_t nxt;
      case (cur)
         OFF_MODE:  nxt = PWM_MODE;
         PWM_MODE:  nxt = R2R_MODE;
         R2R_MODE:  nxt = SAW_MODE;
         SAW_MODE:  nxt = BUZ_MODE;
         BUZ_MODE:  nxt = CHRIP_MODE;
         default:   nxt = PWM_MODE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/output_mode_sequencer_cycle_timer.sv
// Down-counter shared by the BLANK and DWELL phases. A start pulse loads the
// count; done_o is high during the final cycle of the loaded interval.
module cycle_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] load_i,
   input  logic         start_i,
   output logic         done_o
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Reload on start, otherwise count down and rest at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = load_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
      end
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == ONE);

endmodule

// File: rtl/output_mode_sequencer.sv
// Mode-change sequencer in front of output_mode_fsm: handshake intake,
// break-before-make blanking, minimum dwell and optional auto-scan.
module output_mode_sequencer
   import output_mode_pkg::*;
#(
   parameter int unsigned DEAD_CYCLES = 1000,
   parameter int unsigned MIN_DWELL   = 100000,
   parameter int unsigned SCAN_PERIOD = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [2:0] req_mode,
   output logic       req_ready,
   input  logic       scan_en,
   output logic [2:0] mode_select,
   output logic [2:0] active_mode,
   output logic       switching,
   output logic       invalid_req
);

   localparam int unsigned TMAX = (DEAD_CYCLES > MIN_DWELL) ? DEAD_CYCLES : MIN_DWELL;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam int unsigned SW   = $clog2(SCAN_PERIOD);

   localparam logic [TW-1:0] DEAD_LD   = TW'(DEAD_CYCLES);
   localparam logic [TW-1:0] DWELL_LD  = TW'(MIN_DWELL);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_PERIOD - 1);

   typedef enum logic [1:0] {
      S_HOLD,
      S_BLANK,
      S_DWELL
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    ms_q, ms_d;
   logic [2:0]    act_q, act_d;
   logic [2:0]    tgt_q, tgt_d;
   logic          inv_q, inv_d;
   logic [SW-1:0] scan_q, scan_d;

   logic          t_start;
   logic [TW-1:0] t_load;
   logic          t_done;
   logic          acc;
   logic [2:0]    code;

   cycle_timer #(
      .W (TW)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .load_i  (t_load),
      .start_i (t_start),
      .done_o  (t_done)
   );

   // Next-state logic: request arbitration in HOLD, timed BLANK/DWELL phases.
   always_comb begin
      state_d = state_q;
      ms_d    = ms_q;
      act_d   = act_q;
      tgt_d   = tgt_q;
      inv_d   = 1'b0;
      scan_d  = '0;
      t_start = 1'b0;
      t_load  = DWELL_LD;
      acc     = 1'b0;
      code    = req_mode;
      case (state_q)
         S_HOLD: begin
            // External request wins over a coincident scan tick; either way
            // the scan counter restarts from zero.
            if (req_valid) begin
               acc  = 1'b1;
               code = req_mode;
            end else if (scan_en) begin
               if (scan_q == SCAN_LAST) begin
                  acc  = 1'b1;
                  code = next_scan_mode(mode_t'(act_q));
               end else begin
                  scan_d = scan_q + SW'(1);
               end
            end
            if (acc) begin
               if (!is_valid_mode(code)) begin
                  inv_d = 1'b1;
               end else if (code == act_q) begin
                  state_d = S_HOLD;
               end else if ((code == OFF_MODE) || (act_q == OFF_MODE)) begin
                  // Output is or becomes OFF: nothing to blank.
                  ms_d    = code;
                  act_d   = code;
                  state_d = S_DWELL;
                  t_start = 1'b1;
                  t_load  = DWELL_LD;
               end else begin
                  tgt_d   = code;
                  ms_d    = OFF_MODE;
                  state_d = S_BLANK;
                  t_start = 1'b1;
                  t_load  = DEAD_LD;
               end
            end
         end
         S_BLANK: begin
            if (t_done) begin
               ms_d    = tgt_q;
               act_d   = tgt_q;
               state_d = S_DWELL;
               t_start = 1'b1;
               t_load  = DWELL_LD;
            end
         end
         S_DWELL: begin
            if (t_done) begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d = S_HOLD;
         end
      endcase
   end

   // State and output registers; reset discards any latched target.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_HOLD;
         ms_q    <= OFF_MODE;
         act_q   <= OFF_MODE;
         tgt_q   <= OFF_MODE;
         inv_q   <= 1'b0;
         scan_q  <= '0;
      end else begin
         state_q <= state_d;
         ms_q    <= ms_d;
         act_q   <= act_d;
         tgt_q   <= tgt_d;
         inv_q   <= inv_d;
         scan_q  <= scan_d;
      end
   end

   assign req_ready   = (state_q == S_HOLD);
   assign switching   = (state_q != S_HOLD);
   assign mode_select = ms_q;
   assign active_mode = act_q;
   assign invalid_req = inv_q;

endmodule

// File: tb/tb_output_mode_sequencer.sv
// Randomised and directed bench for output_mode_sequencer against a
// cycle-schedule reference model.
module tb_output_mode_sequencer;

   localparam int DEAD  = 4;
   localparam int DWELL = 8;
   localparam int SCANP = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic [2:0] req_mode;
   logic       req_ready;
   logic       scan_en;
   logic [2:0] mode_select;
   logic [2:0] active_mode;
   logic       switching;
   logic       invalid_req;

   output_mode_sequencer #(
      .DEAD_CYCLES (DEAD),
      .MIN_DWELL   (DWELL),
      .SCAN_PERIOD (SCANP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_mode    (req_mode),
      .req_ready   (req_ready),
      .scan_en     (scan_en),
      .mode_select (mode_select),
      .active_mode (active_mode),
      .switching   (switching),
      .invalid_req (invalid_req)
   );

   always #5 clk = ~clk;

   // Reference model: edge count plus scheduled future events.
   int         cyc, ready_at, pend_edge, run;
   logic [2:0] exp_ms, exp_act, pend_mode;
   logic       exp_inv;
   bit         m_ext_acc;
   int         n_vec = 0;
   int         n_err = 0;
   logic [2:0] scan_log[$];
   logic [2:0] prev_act;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      cyc = 0; ready_at = 0; pend_edge = -1; run = 0;
      exp_ms = 3'd0; exp_act = 3'd0; exp_inv = 1'b0; m_ext_acc = 1'b0;
      pend_mode = 3'd0; prev_act = 3'd0;
   endtask

   task automatic model_edge();
      bit         hold;
      bit         acc;
      logic [2:0] code;
      hold = (cyc >= ready_at);
      acc = 1'b0; code = 3'd0; m_ext_acc = 1'b0; exp_inv = 1'b0;
      cyc++;
      if (pend_edge == cyc) begin
         exp_ms = pend_mode; exp_act = pend_mode; pend_edge = -1;
      end
      if (hold && req_valid) begin
         acc = 1'b1; m_ext_acc = 1'b1; code = req_mode; run = 0;
      end else if (hold && scan_en) begin
         run++;
         if (run == SCANP) begin
            acc = 1'b1; code = 3'((int'(exp_act) % 5) + 1); run = 0;
         end
      end else begin
         run = 0;
      end
      if (acc) begin
         if (code > 3'd5) begin
            exp_inv = 1'b1;
         end else if (code == exp_act) begin
            exp_inv = 1'b0;
         end else if (code == 3'd0 || exp_act == 3'd0) begin
            exp_ms = code; exp_act = code; ready_at = cyc + DWELL;
         end else begin
            exp_ms = 3'd0; pend_mode = code;
            pend_edge = cyc + DEAD; ready_at = cyc + DEAD + DWELL;
         end
      end
   endtask

   task automatic tick();
      bit hs;
      hs = req_valid && req_ready;
      @(posedge clk);
      model_edge();
      #1;
      check("handshake", 8'(hs), 8'(m_ext_acc));
      check("mode_select", 8'(mode_select), 8'(exp_ms));
      check("active_mode", 8'(active_mode), 8'(exp_act));
      check("req_ready", 8'(req_ready), 8'(cyc >= ready_at));
      check("switching", 8'(switching), 8'(cyc < ready_at));
      check("invalid_req", 8'(invalid_req), 8'(exp_inv));
      if (active_mode != prev_act) scan_log.push_back(active_mode);
      prev_act = active_mode;
   endtask

   task automatic wait_ready(input int limit);
      int k;
      k = 0;
      while (!req_ready && k < limit) begin
         tick();
         k++;
      end
      check("ready_timeout", 8'(req_ready), 8'd1);
   endtask

   task automatic send(input logic [2:0] m);
      req_valid = 1'b1;
      req_mode  = m;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      int k;
      logic [2:0] exp_seq[6];
      exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};

      // Reset and idle.
      reset = 1'b1; req_valid = 1'b0; req_mode = 3'd0; scan_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      check("rst_mode_select", 8'(mode_select), 8'd0);
      check("rst_active_mode", 8'(active_mode), 8'd0);
      check("rst_req_ready", 8'(req_ready), 8'd1);
      check("rst_switching", 8'(switching), 8'd0);
      check("rst_invalid", 8'(invalid_req), 8'd0);
      repeat (10) tick();

      // OFF -> PWM applies directly, no blank.
      send(3'd1);
      check("off_to_pwm_direct", 8'(mode_select), 8'd1);
      wait_ready(50);

      // PWM -> BUZ with blanking, then R2R held through the dwell.
      send(3'd4);
      check("blank_starts", 8'(mode_select), 8'd0);
      req_valid = 1'b1; req_mode = 3'd2;
      k = 0;
      do begin
         tick();
         k++;
      end while (!m_ext_acc && k < 60);
      req_valid = 1'b0;
      check("stall_len", 8'(k), 8'(DEAD + DWELL + 1));
      wait_ready(60);
      check("after_r2r", 8'(mode_select), 8'd2);

      // Invalid code, then a same-mode request.
      send(3'd7);
      check("invalid_pulse", 8'(invalid_req), 8'd1);
      tick();
      check("invalid_one_cycle", 8'(invalid_req), 8'd0);
      send(3'd2);
      check("same_mode_no_switch", 8'(switching), 8'd0);
      tick();

      // Back to OFF, then auto-scan.
      send(3'd0);
      wait_ready(50);
      scan_log.delete();
      scan_en = 1'b1;
      k = 0;
      while (scan_log.size() < 6 && k < 400) begin
         tick();
         k++;
      end
      check("scan_steps", 8'(scan_log.size()), 8'd6);
      for (int i = 0; i < 6 && i < scan_log.size(); i++) begin
         check($sformatf("scan_seq_%0d", i), 8'(scan_log[i]), 8'(exp_seq[i]));
      end

      // Reset in the middle of a blank.
      k = 0;
      while (!(pend_edge >= 0 && pend_edge - cyc >= 2) && k < 200) begin
         tick();
         k++;
      end
      check("reached_blank", 8'(mode_select == 3'd0 && switching), 8'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_mode", 8'(mode_select), 8'd0);
      check("async_rst_active", 8'(active_mode), 8'd0);
      check("async_rst_ready", 8'(req_ready), 8'd1);
      check("async_rst_switch", 8'(switching), 8'd0);
      scan_en = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      repeat (3) tick();

      // Randomised traffic.
      for (int i = 0; i < 2000; i++) begin
         if (!req_valid && $urandom_range(7) == 0) begin
            req_valid = 1'b1;
            req_mode  = 3'($urandom_range(7));
         end
         if ($urandom_range(63) == 0) scan_en = ~scan_en;
         tick();
         if (m_ext_acc) req_valid = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
